// File: rtl/huffman_decoder.sv
// Serial Huffman decoder for the 6-symbol gray-level coder: captures the
// encoder's code table, then turns a one-bit-per-handshake stream into gray values 1..6.
module huffman_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        code_valid,
  input  logic [7:0]  HC1,
  input  logic [7:0]  HC2,
  input  logic [7:0]  HC3,
  input  logic [7:0]  HC4,
  input  logic [7:0]  HC5,
  input  logic [7:0]  HC6,
  input  logic [7:0]  M1,
  input  logic [7:0]  M2,
  input  logic [7:0]  M3,
  input  logic [7:0]  M4,
  input  logic [7:0]  M5,
  input  logic [7:0]  M6,
  input  logic        bit_valid,
  input  logic        bit_in,
  output logic        bit_ready,
  output logic        sym_valid,
  output logic [7:0]  sym_data,
  output logic        err,
  output logic [15:0] sym_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DECODE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  hc_q [6];
  logic [7:0]  hc_d [6];
  logic [7:0]  m_q  [6];
  logic [7:0]  m_d  [6];
  logic [7:0]  acc_q, acc_d;
  logic [3:0]  len_q, len_d;
  logic        bit_ready_q, bit_ready_d;
  logic        sym_valid_q, sym_valid_d;
  logic [7:0]  sym_data_q, sym_data_d;
  logic        err_q, err_d;
  logic [15:0] sym_cnt_q, sym_cnt_d;

  logic        accept_s;
  logic [7:0]  acc_n_s;
  logic [3:0]  len_n_s;
  logic [7:0]  want_mask_s;
  logic [5:0]  hit_s;
  logic [2:0]  hit_idx_s;

  // Lowest-index wins so non-prefix-free tables still decode deterministically.
  function automatic logic [2:0] first_hit(input logic [5:0] hits);
    logic [2:0] idx;
    casez (hits)
      6'b?????1: idx = 3'd1;
      6'b????10: idx = 3'd2;
      6'b???100: idx = 3'd3;
      6'b??1000: idx = 3'd4;
      6'b?10000: idx = 3'd5;
      6'b100000: idx = 3'd6;
      default:   idx = 3'd0;
    endcase
    return idx;
  endfunction

  // Candidate accumulator after the incoming bit and the per-symbol match vector.
  always_comb begin
    accept_s    = bit_valid && bit_ready_q && (state_q == ST_DECODE);
    acc_n_s     = {acc_q[6:0], bit_in};
    len_n_s     = len_q + 4'd1;
    want_mask_s = 8'hFF >> (4'd8 - len_n_s);
    for (int i = 0; i < 6; i++) begin
      hit_s[i] = (m_q[i] != 8'd0) && (m_q[i] == want_mask_s) &&
                 ((acc_n_s & m_q[i]) == hc_q[i]);
    end
    hit_idx_s = first_hit(hit_s);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; DECODE is left only through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (code_valid) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD:   state_d = ST_DECODE;
      ST_DECODE: state_d = ST_DECODE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM output and datapath next values.
  always_comb begin
    hc_d        = hc_q;
    m_d         = m_q;
    acc_d       = acc_q;
    len_d       = len_q;
    sym_data_d  = sym_data_q;
    sym_cnt_d   = sym_cnt_q;
    sym_valid_d = 1'b0;
    err_d       = 1'b0;
    bit_ready_d = (state_q == ST_DECODE);
    case (state_q)
      ST_IDLE: begin
        if (code_valid) begin
          hc_d[0] = HC1;  hc_d[1] = HC2;  hc_d[2] = HC3;
          hc_d[3] = HC4;  hc_d[4] = HC5;  hc_d[5] = HC6;
          m_d[0]  = M1;   m_d[1]  = M2;   m_d[2]  = M3;
          m_d[3]  = M4;   m_d[4]  = M5;   m_d[5]  = M6;
        end else begin
          hc_d = hc_q;
          m_d  = m_q;
        end
      end
      ST_LOAD: begin
        acc_d = 8'd0;
        len_d = 4'd0;
      end
      ST_DECODE: begin
        if (!accept_s) begin
          acc_d = acc_q;
          len_d = len_q;
        end else if (hit_idx_s != 3'd0) begin
          sym_data_d  = {5'd0, hit_idx_s};
          sym_valid_d = 1'b1;
          sym_cnt_d   = sym_cnt_q + 16'd1;
          acc_d       = 8'd0;
          len_d       = 4'd0;
        end else if (len_n_s == 4'd8) begin
          err_d = 1'b1;
          acc_d = 8'd0;
          len_d = 4'd0;
        end else begin
          acc_d = acc_n_s;
          len_d = len_n_s;
        end
      end
      default: begin
        acc_d = 8'd0;
        len_d = 4'd0;
      end
    endcase
  end

  // Table, accumulator and registered output flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        hc_q[i] <= 8'd0;
        m_q[i]  <= 8'd0;
      end
      acc_q       <= 8'd0;
      len_q       <= 4'd0;
      bit_ready_q <= 1'b0;
      sym_valid_q <= 1'b0;
      sym_data_q  <= 8'd0;
      err_q       <= 1'b0;
      sym_cnt_q   <= 16'd0;
    end else begin
      hc_q        <= hc_d;
      m_q         <= m_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      bit_ready_q <= bit_ready_d;
      sym_valid_q <= sym_valid_d;
      sym_data_q  <= sym_data_d;
      err_q       <= err_d;
      sym_cnt_q   <= sym_cnt_d;
    end
  end

  assign bit_ready = bit_ready_q;
  assign sym_valid = sym_valid_q;
  assign sym_data  = sym_data_q;
  assign err       = err_q;
  assign sym_cnt   = sym_cnt_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Scoreboard bench for huffman_decoder: expected symbols/errors are queued
// as codeword bits are driven and matched against output pulses.
module tb_huffman_decoder;

  logic        clk;
  logic        reset;
  logic        code_valid;
  logic [7:0]  hc_r [1:6];
  logic [7:0]  m_r  [1:6];
  logic        bit_valid;
  logic        bit_in;
  logic        bit_ready;
  logic        sym_valid;
  logic [7:0]  sym_data;
  logic        err;
  logic [15:0] sym_cnt;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  huffman_decoder dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(hc_r[1]), .HC2(hc_r[2]), .HC3(hc_r[3]),
    .HC4(hc_r[4]), .HC5(hc_r[5]), .HC6(hc_r[6]),
    .M1(m_r[1]), .M2(m_r[2]), .M3(m_r[3]),
    .M4(m_r[4]), .M5(m_r[5]), .M6(m_r[6]),
    .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready),
    .sym_valid(sym_valid), .sym_data(sym_data), .err(err), .sym_cnt(sym_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle stamp used to check one-cycle decode latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Output monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (sym_valid && err) begin
        check("valid_and_err", 32'd1, 32'd0);
      end else if (sym_valid || err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, err, sym_valid}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("pulse_kind", {31'd0, err}, {31'd0, mon_e.is_err});
          check("pulse_cycle", mon_e.cyc, mon_e.cyc == cyc ? cyc : cyc);
          check("pulse_latency", cyc, mon_e.cyc);
          check("sym_data", {24'd0, sym_data}, {24'd0, mon_e.data});
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    bit_valid = 1'b0;
    code_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic set_table(input logic zero_m6);
    hc_r[1] = 8'd0;  hc_r[2] = 8'd2;  hc_r[3] = 8'd6;
    hc_r[4] = 8'd14; hc_r[5] = 8'd30; hc_r[6] = 8'd31;
    m_r[1]  = 8'd1;  m_r[2]  = 8'd3;  m_r[3]  = 8'd7;
    m_r[4]  = 8'd15; m_r[5]  = 8'd31; m_r[6]  = zero_m6 ? 8'd0 : 8'd31;
  endtask

  // Raise code_valid at a negedge; edge N samples it, bit_ready must rise at edge N+2.
  task automatic load_table(input logic zero_m6);
    set_table(zero_m6);
    code_valid = 1'b1;
    @(negedge clk);
    check("rdy_after_N", {31'd0, bit_ready}, 32'd0);
    @(negedge clk);
    check("rdy_after_N1", {31'd0, bit_ready}, 32'd0);
    code_valid = 1'b0;
    @(negedge clk);
    check("rdy_after_N2", {31'd0, bit_ready}, 32'd1);
  endtask

  // Drive one bit for one handshake; optionally queue the pulse it completes.
  task automatic send_bit(input logic b, input logic push, input logic is_err, input logic [7:0] data);
    exp_t e;
    int   t;
    t = 0;
    while (!bit_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bit_ready) check("bit_ready_timeout", 32'd0, 32'd1);
    bit_valid = 1'b1;
    bit_in = b;
    if (push) begin
      e.is_err = is_err;
      e.data = data;
      e.cyc = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic send_sym(input int s);
    int len;
    len = 0;
    for (int b = 0; b < 8; b++) len += m_r[s][b];
    for (int b = len - 1; b >= 0; b--) begin
      send_bit(hc_r[s][b], b == 0, 1'b0, s[7:0]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    idle(4);
    check(tag, exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int syms[100];
    reset = 1'b1;
    code_valid = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    set_table(1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_bit_ready", {31'd0, bit_ready}, 32'd0);
    check("rst_sym_valid", {31'd0, sym_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_sym_data", {24'd0, sym_data}, 32'd0);
    check("rst_sym_cnt", {16'd0, sym_cnt}, 32'd0);

    // Bits before the table is loaded are ignored.
    bit_valid = 1'b1;
    bit_in = 1'b0;
    idle(5);
    bit_valid = 1'b0;
    check("early_sym_cnt", {16'd0, sym_cnt}, 32'd0);

    // Basic back-to-back decode: 0 | 10 | 11111 -> 1, 2, 6.
    load_table(1'b0);
    send_sym(1);
    send_sym(2);
    send_sym(6);
    drain("basic_drain");
    check("basic_sym_cnt", {16'd0, sym_cnt}, 32'd3);
    check("basic_hold", {24'd0, sym_data}, 32'd6);

    // Gapped stream 1,1,0 -> 3.
    send_bit(1'b1, 1'b0, 1'b0, 8'd0);
    idle(2);
    send_bit(1'b1, 1'b0, 1'b0, 8'd0);
    idle(2);
    send_bit(1'b0, 1'b1, 1'b0, 8'd3);
    drain("gap_drain");
    check("gap_sym_cnt", {16'd0, sym_cnt}, 32'd4);

    // Error path: M6=0, eight ones give one err, then 0 decodes to 1.
    apply_reset();
    load_table(1'b1);
    for (int i = 0; i < 8; i++) send_bit(1'b1, i == 7, 1'b1, 8'd0);
    drain("err_drain");
    check("err_sym_cnt", {16'd0, sym_cnt}, 32'd0);
    check("err_data_hold", {24'd0, sym_data}, 32'd0);
    send_bit(1'b0, 1'b1, 1'b0, 8'd1);
    drain("after_err_drain");
    check("after_err_cnt", {16'd0, sym_cnt}, 32'd1);

    // Reset after two bits of 1110 discards the partial codeword.
    apply_reset();
    load_table(1'b0);
    send_bit(1'b1, 1'b0, 1'b0, 8'd0);
    send_bit(1'b1, 1'b0, 1'b0, 8'd0);
    apply_reset();
    check("midrst_cnt", {16'd0, sym_cnt}, 32'd0);
    check("midrst_ready", {31'd0, bit_ready}, 32'd0);
    load_table(1'b0);
    send_sym(4);
    drain("midrst_drain");
    check("midrst_data", {24'd0, sym_data}, 32'd4);
    check("midrst_cnt_after", {16'd0, sym_cnt}, 32'd1);

    // Round trip of a 100-pixel image with occasional idle gaps.
    apply_reset();
    load_table(1'b0);
    for (int i = 0; i < 100; i++) syms[i] = $urandom_range(1, 6);
    syms[0] = 6;
    syms[1] = 1;
    for (int i = 0; i < 100; i++) begin
      send_sym(syms[i]);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    drain("rt_drain");
    check("rt_sym_cnt", {16'd0, sym_cnt}, 32'd100);
    check("rt_last_data", {24'd0, sym_data}, syms[99]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
